// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bus between the control unit, div_sequencer and
// the combinational array divider.
interface div_sequencer_if;
  logic        in_start;
  logic        in_flush;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [31:0] out_dividend;
  logic [31:0] out_divisor;
  logic [31:0] in_quotient;
  logic [31:0] in_remainder;
  logic        out_ready;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_lo;
  logic [31:0] out_hi;
  logic        out_div_zero;

  modport slave (
    input  in_start, in_flush, in_dividend, in_divisor, in_quotient, in_remainder,
    output out_dividend, out_divisor, out_ready, out_busy, out_done,
           out_lo, out_hi, out_div_zero
  );

  modport master (
    output in_start, in_flush, in_dividend, in_divisor, in_quotient, in_remainder,
    input  out_dividend, out_divisor, out_ready, out_busy, out_done,
           out_lo, out_hi, out_div_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Multicycle controller for the combinational signed divider: holds operands for
// WAIT_CYCLES clocks, then latches HI/LO. Optional macro: DIV_ZERO_TRAP_EN.
module div_sequencer #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic           in_clk,
  input  logic           in_reset_n,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_trap_hit;
  logic             w_write;

  assign w_accept   = (r_state == S_IDLE) && bus.in_start && !bus.in_flush;
  assign w_cnt_zero = (r_cnt == '0);

`ifdef DIV_ZERO_TRAP_EN
  // A zero divisor seen at accept short-circuits the wait on the following edge.
  logic r_trap;
  logic r_div_zero;
  assign w_trap_hit       = (r_state == S_WAIT) && !bus.in_flush && r_trap;
  assign bus.out_div_zero = r_div_zero;
`else
  assign w_trap_hit       = 1'b0;
  assign bus.out_div_zero = 1'b0;
`endif

  assign w_write = (r_state == S_WAIT) && !bus.in_flush && w_cnt_zero && !w_trap_hit;

  // Next-state decode; flush always returns to IDLE without a result write.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.in_flush) begin
          w_next_state = S_IDLE;
        end else if (w_trap_hit || w_cnt_zero) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, operand holding, counter and result registers.
  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_lo       <= 32'd0;
      r_hi       <= 32'd0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_trap     <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);
      r_busy  <= (w_next_state == S_WAIT);
      r_done  <= (w_next_state == S_DONE);
      if (w_accept) begin
        r_dividend <= bus.in_dividend;
        r_divisor  <= bus.in_divisor;
        r_cnt      <= LP_CNT_LOAD;
`ifdef DIV_ZERO_TRAP_EN
        r_trap     <= (bus.in_divisor == 32'd0);
        r_div_zero <= 1'b0;
`endif
      end else if ((r_state == S_WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - LP_CNT_ONE;
      end
      if (w_write) begin
        r_lo <= bus.in_quotient;
        r_hi <= bus.in_remainder;
      end
`ifdef DIV_ZERO_TRAP_EN
      if (w_trap_hit) begin
        r_div_zero <= 1'b1;
      end
`endif
    end
  end

  assign bus.out_dividend = r_dividend;
  assign bus.out_divisor  = r_divisor;
  assign bus.out_lo       = r_lo;
  assign bus.out_hi       = r_hi;
  assign bus.out_ready    = r_ready;
  assign bus.out_busy     = r_busy;
  assign bus.out_done     = r_done;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a behavioural model of the
// Mini-SRC divider (truncating quotient, magnitude remainder).
module tb_div_sequencer;
  logic in_clk;
  logic in_reset_n;
  int   checks;
  int   failures;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  div_sequencer_if bus ();

  div_sequencer #(.WAIT_CYCLES(4), .CNT_W(4)) dut (
    .in_clk     (in_clk),
    .in_reset_n (in_reset_n),
    .bus        (bus)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  // Divider model fed from the registered operands.
  always_comb begin
    abs_a = bus.out_dividend[31] ? (32'd0 - bus.out_dividend) : bus.out_dividend;
    abs_b = bus.out_divisor[31]  ? (32'd0 - bus.out_divisor)  : bus.out_divisor;
    if (bus.out_divisor == 32'd0) begin
      bus.in_quotient  = 32'hFFFF_FFFF;
      bus.in_remainder = bus.out_dividend;
    end else begin
      bus.in_quotient  = $signed(bus.out_dividend) / $signed(bus.out_divisor);
      bus.in_remainder = abs_a % abs_b;
    end
  end

  task automatic step();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] a, input logic [31:0] b);
    bus.in_start    = s;
    bus.in_flush    = f;
    bus.in_dividend = a;
    bus.in_divisor  = b;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'd30, 32'd4);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    in_reset_n = 1'b0;
    step();
    step();
    in_reset_n = 1'b1;
    checks++; if (bus.out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.out_ready); end
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.out_busy); end
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.out_done); end
    checks++; if ({bus.out_hi, bus.out_lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {bus.out_hi, bus.out_lo}); end
    checks++; if ({bus.out_dividend, bus.out_divisor} !== 64'd0) begin failures++; $display("FAIL reset_ops got=%h exp=0", {bus.out_dividend, bus.out_divisor}); end
    checks++; if (bus.out_div_zero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", bus.out_div_zero); end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 32'd30, 32'd4);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if ({bus.out_busy, bus.out_ready} !== 2'b10) begin failures++; $display("FAIL basic_accept busy/ready got=%b exp=10", {bus.out_busy, bus.out_ready}); end
    checks++; if (bus.out_dividend !== 32'd30) begin failures++; $display("FAIL basic_opnd got=%0d exp=30", bus.out_dividend); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if ({bus.out_busy, bus.out_done, bus.out_lo} !== {2'b10, 32'd0}) begin failures++; $display("FAIL basic_wait%0d busy/done/lo got=%b%b/%h exp=10/0", i, bus.out_busy, bus.out_done, bus.out_lo); end
    end
    step();
    checks++; if ({bus.out_done, bus.out_busy, bus.out_ready} !== 3'b100) begin failures++; $display("FAIL basic_done_flags got=%b exp=100", {bus.out_done, bus.out_busy, bus.out_ready}); end
    checks++; if (bus.out_lo !== 32'd7) begin failures++; $display("FAIL basic_lo got=%0d exp=7", bus.out_lo); end
    checks++; if (bus.out_hi !== 32'd2) begin failures++; $display("FAIL basic_hi got=%0d exp=2", bus.out_hi); end
    step();
    checks++; if ({bus.out_done, bus.out_ready} !== 2'b01) begin failures++; $display("FAIL basic_idle done/ready got=%b exp=01", {bus.out_done, bus.out_ready}); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 32'hFFFF_FE0C, 32'd3);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step(); step(); step(); step();
    checks++; if ({bus.out_lo, bus.out_hi} !== {32'hFFFF_FF5A, 32'd2}) begin failures++; $display("FAIL signed_neg lo/hi got=%h/%h exp=ffffff5a/2", bus.out_lo, bus.out_hi); end
    drive(1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF7);
    step();
    checks++; if ({bus.out_ready, bus.out_busy} !== 2'b10) begin failures++; $display("FAIL b2b_done_edge ready/busy got=%b exp=10", {bus.out_ready, bus.out_busy}); end
    checks++; if (bus.out_dividend !== 32'hFFFF_FE0C) begin failures++; $display("FAIL b2b_no_early_accept got=%h exp=fffffe0c", bus.out_dividend); end
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if ({bus.out_busy, bus.out_dividend} !== {1'b1, 32'hFFFF_FF9C}) begin failures++; $display("FAIL b2b_accept busy/opnd got=%b/%h exp=1/ffffff9c", bus.out_busy, bus.out_dividend); end
    step(); step(); step(); step();
    checks++; if ({bus.out_done, bus.out_lo, bus.out_hi} !== {1'b1, 32'd11, 32'd1}) begin failures++; $display("FAIL signed_both done/lo/hi got=%b/%h/%h exp=1/b/1", bus.out_done, bus.out_lo, bus.out_hi); end
    step();
  endtask

  task automatic test_start_while_busy();
    drive(1'b1, 1'b0, 32'd100, 32'd7);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'd8, 32'd2);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if ({bus.out_dividend, bus.out_divisor} !== {32'd100, 32'd7}) begin failures++; $display("FAIL busy_ops_held got=%h exp=%h", {bus.out_dividend, bus.out_divisor}, {32'd100, 32'd7}); end
    step(); step();
    checks++; if ({bus.out_done, bus.out_lo, bus.out_hi} !== {1'b1, 32'd14, 32'd2}) begin failures++; $display("FAIL busy_result done/lo/hi got=%b/%0d/%0d exp=1/14/2", bus.out_done, bus.out_lo, bus.out_hi); end
    step(); step();
    checks++; if ({bus.out_ready, bus.out_busy} !== 2'b10) begin failures++; $display("FAIL busy_not_queued ready/busy got=%b exp=10", {bus.out_ready, bus.out_busy}); end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 32'd50, 32'd5);
    step();
    checks++; if ({bus.out_ready, bus.out_busy, bus.out_dividend} !== {2'b10, 32'd100}) begin failures++; $display("FAIL flush_idle_block ready/busy/opnd got=%b%b/%0d exp=10/100", bus.out_ready, bus.out_busy, bus.out_dividend); end
    drive(1'b1, 1'b0, 32'd10, 32'd1);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step(); step();
    drive(1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'd9, 32'd3);
    checks++; if ({bus.out_ready, bus.out_busy, bus.out_done} !== 3'b100) begin failures++; $display("FAIL flush_to_idle r/b/d got=%b exp=100", {bus.out_ready, bus.out_busy, bus.out_done}); end
    checks++; if ({bus.out_lo, bus.out_hi} !== {32'd14, 32'd2}) begin failures++; $display("FAIL flush_hilo_kept got=%0d/%0d exp=14/2", bus.out_lo, bus.out_hi); end
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if ({bus.out_busy, bus.out_dividend} !== {1'b1, 32'd9}) begin failures++; $display("FAIL flush_reaccept busy/opnd got=%b/%0d exp=1/9", bus.out_busy, bus.out_dividend); end
    step(); step(); step(); step();
    checks++; if ({bus.out_done, bus.out_lo, bus.out_hi} !== {1'b1, 32'd3, 32'd0}) begin failures++; $display("FAIL flush_next_result done/lo/hi got=%b/%0d/%0d exp=1/3/0", bus.out_done, bus.out_lo, bus.out_hi); end
    step();
  endtask

  task automatic test_div_zero();
    drive(1'b1, 1'b0, 32'd5, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (bus.out_busy !== 1'b1) begin failures++; $display("FAIL dz_accept busy got=%b exp=1", bus.out_busy); end
`ifdef DIV_ZERO_TRAP_EN
    step();
    checks++; if ({bus.out_done, bus.out_div_zero, bus.out_busy} !== 3'b110) begin failures++; $display("FAIL dz_trap done/dz/busy got=%b exp=110", {bus.out_done, bus.out_div_zero, bus.out_busy}); end
    checks++; if ({bus.out_lo, bus.out_hi} !== {32'd3, 32'd0}) begin failures++; $display("FAIL dz_hilo_kept got=%0d/%0d exp=3/0", bus.out_lo, bus.out_hi); end
    step();
    checks++; if ({bus.out_done, bus.out_ready, bus.out_div_zero} !== 3'b011) begin failures++; $display("FAIL dz_held done/ready/dz got=%b exp=011", {bus.out_done, bus.out_ready, bus.out_div_zero}); end
    drive(1'b1, 1'b0, 32'd20, 32'd5);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (bus.out_div_zero !== 1'b0) begin failures++; $display("FAIL dz_clear got=%b exp=0", bus.out_div_zero); end
    step(); step(); step(); step();
    checks++; if ({bus.out_done, bus.out_lo, bus.out_hi} !== {1'b1, 32'd4, 32'd0}) begin failures++; $display("FAIL dz_after done/lo/hi got=%b/%0d/%0d exp=1/4/0", bus.out_done, bus.out_lo, bus.out_hi); end
`else
    step(); step(); step();
    checks++; if ({bus.out_busy, bus.out_done} !== 2'b10) begin failures++; $display("FAIL dz_wait busy/done got=%b exp=10", {bus.out_busy, bus.out_done}); end
    step();
    checks++; if ({bus.out_done, bus.out_div_zero} !== 2'b10) begin failures++; $display("FAIL dz_done done/dz got=%b exp=10", {bus.out_done, bus.out_div_zero}); end
    checks++; if ({bus.out_lo, bus.out_hi} !== {32'hFFFF_FFFF, 32'd5}) begin failures++; $display("FAIL dz_hilo got=%h/%h exp=ffffffff/5", bus.out_lo, bus.out_hi); end
`endif
    step();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    in_reset_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge in_clk);
    step();
    step();
    in_reset_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_flush();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
